ibex_mem_responder: RTL and testbench

Memory-side responder for the ibex instruction/data request interface (req/gnt/rvalid). Owns a word-addressed SRAM, grants requests subject to a stall input and an outstanding-transaction cap, and returns in-order responses a fixed number of cycles after each grant. Used as the instruction or data memory behind the core in simulation and FPGA builds, and as the reference responder in core-level testbenches.

---
 rtl/ibex_mem_responder_if.sv | 23 ++
 rtl/ibex_mem_responder.sv | 79 +++++++
 tb/tb_ibex_mem_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_mem_responder_if.sv
// Core-to-memory request/response bundle (req/gnt/rvalid protocol).
// The core drives the master side; the memory responder sits on the slave side.
interface ibex_mem_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/ibex_mem_responder.sv
// Word-addressed SRAM responder for the req/gnt/rvalid bus: grants under a stall hook
// and an outstanding cap, and returns in-order responses a fixed Latency after grant.
module ibex_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    ibex_mem_responder_if.slave  bus
);
    localparam int              LAT     = int'(Latency);
    localparam int unsigned     IDX_W   = $clog2(MemWords);
    localparam int unsigned     CNT_W   = $clog2(MaxOutstanding + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MaxOutstanding);
    localparam logic [31:0]     SPAN    = 32'(4 * MemWords);

    logic [31:0]            r_mem [MemWords];
    logic [LAT-1:0]         r_vld;
    logic [LAT-1:0]         r_err;
    logic [LAT-1:0][31:0]   r_rdata;
    logic [CNT_W-1:0]       r_inflight;

    logic [32:0]            w_off;
    logic                   w_in_range;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_acc;
    logic                   w_rsp;
    logic [31:0]            w_rd_word;

    // 33-bit difference: bit 32 set means the address lies below BaseAddr.
    assign w_off      = {1'b0, bus.addr_i} - {1'b0, BaseAddr};
    assign w_in_range = ~w_off[32] & (w_off[31:0] < SPAN);
    assign w_idx      = w_off[IDX_W+1:2];
    assign w_rd_word  = r_mem[w_idx];

    assign w_rsp = r_vld[LAT-1];
    // A response leaving this cycle frees its slot for a same-cycle accept.
    assign w_acc = bus.req_i & ~stall_i & ~rst_i & ((r_inflight < MAX_CNT) | w_rsp);

    assign bus.gnt_o    = w_acc;
    assign bus.rvalid_o = w_rsp;
    assign bus.err_o    = r_err[LAT-1];
    assign bus.rdata_o  = r_rdata[LAT-1];

    always_ff @(posedge clk_i) begin
        if (w_acc & bus.we_i & w_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be_i[k]) r_mem[w_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld      <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
            r_inflight <= '0;
        end else begin
            // Invalid stages carry zero data/err so outputs are clean when rvalid is low.
            r_vld[0]   <= w_acc;
            r_err[0]   <= w_acc & ~w_in_range;
            r_rdata[0] <= (w_acc & ~bus.we_i & w_in_range) ? w_rd_word : 32'h0;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_err[i]   <= r_err[i-1];
                r_rdata[i] <= r_rdata[i-1];
            end
            case ({w_acc, w_rsp})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for ibex_mem_responder: three configurations side by side, a per-cycle
// transaction-level model, and directed scenarios with literal expectations.
module tb_ibex_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int mo_of(input int d);
        case (d)
            0:       return 2;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    logic        req [3];
    logic        we [3];
    logic        stall [3];
    logic [3:0]  be [3];
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic        gnt [3];
    logic        rvalid [3];
    logic        err [3];
    logic [31:0] rdata [3];

    ibex_mem_responder_if bus0 ();
    ibex_mem_responder_if bus1 ();
    ibex_mem_responder_if bus2 ();

    assign bus0.req_i = req[0];  assign bus0.we_i = we[0];  assign bus0.be_i = be[0];
    assign bus0.addr_i = addr[0]; assign bus0.wdata_i = wdata[0];
    assign gnt[0] = bus0.gnt_o; assign rvalid[0] = bus0.rvalid_o;
    assign err[0] = bus0.err_o; assign rdata[0] = bus0.rdata_o;

    assign bus1.req_i = req[1];  assign bus1.we_i = we[1];  assign bus1.be_i = be[1];
    assign bus1.addr_i = addr[1]; assign bus1.wdata_i = wdata[1];
    assign gnt[1] = bus1.gnt_o; assign rvalid[1] = bus1.rvalid_o;
    assign err[1] = bus1.err_o; assign rdata[1] = bus1.rdata_o;

    assign bus2.req_i = req[2];  assign bus2.we_i = we[2];  assign bus2.be_i = be[2];
    assign bus2.addr_i = addr[2]; assign bus2.wdata_i = wdata[2];
    assign gnt[2] = bus2.gnt_o; assign rvalid[2] = bus2.rvalid_o;
    assign err[2] = bus2.err_o; assign rdata[2] = bus2.rdata_o;

    ibex_mem_responder #(.MemWords(16), .BaseAddr(32'h1000), .Latency(2), .MaxOutstanding(2))
        u_dut0 (.clk_i(clk), .rst_i(rst), .stall_i(stall[0]), .bus(bus0));
    ibex_mem_responder #(.MemWords(16), .BaseAddr(32'h1000), .Latency(3), .MaxOutstanding(2))
        u_dut1 (.clk_i(clk), .rst_i(rst), .stall_i(stall[1]), .bus(bus1));
    ibex_mem_responder #(.MemWords(16), .BaseAddr(32'h1000), .Latency(1), .MaxOutstanding(1))
        u_dut2 (.clk_i(clk), .rst_i(rst), .stall_i(stall[2]), .bus(bus2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: memory image plus a schedule of expected responses keyed by due cycle.
    logic [31:0] mm [3][16];
    logic        rv [3][8];
    logic        re [3][8];
    logic [31:0] rd [3][8];

    initial begin
        int s, n, slot, idx;
        logic eg, ok;
        logic [31:0] off;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst) for (int k = 0; k < 8; k++) rv[d][k] = 1'b0;
                s = cyc % 8;
                chk($sformatf("rvalid%0d", d), {31'b0, rvalid[d]}, {31'b0, rv[d][s]});
                chk($sformatf("err%0d", d), {31'b0, err[d]}, {31'b0, rv[d][s] ? re[d][s] : 1'b0});
                chk($sformatf("rdata%0d", d), rdata[d], rv[d][s] ? rd[d][s] : 32'h0);
                rv[d][s] = 1'b0;
                n = 0;
                for (int k = 1; k <= 4; k++) if (rv[d][(cyc + k) % 8]) n++;
                eg = req[d] & ~stall[d] & ~rst & (n < mo_of(d));
                chk($sformatf("gnt%0d", d), {31'b0, gnt[d]}, {31'b0, eg});
                if (eg) begin
                    ok   = (addr[d] >= 32'h1000) && (addr[d] < 32'h1040);
                    off  = addr[d] - 32'h1000;
                    idx  = int'(off[5:2]);
                    slot = (cyc + lat_of(d)) % 8;
                    rv[d][slot] = 1'b1;
                    re[d][slot] = !ok;
                    rd[d][slot] = (ok && !we[d]) ? mm[d][idx] : 32'h0;
                    if (ok && we[d])
                        for (int b = 0; b < 4; b++)
                            if (be[d][b]) mm[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drv(input int d, input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd);
        req[d] = r; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    endtask

    task automatic idle(input int d);
        drv(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            idle(d);
            stall[d] = 1'b0;
        end
        // Reset state with a request pending
        drv(0, 1'b1, 1'b1, 4'hF, 32'h1000, 32'h0);
        step(); at_neg();
        chk("rst_gnt", {31'b0, gnt[0]}, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid[0]}, 32'h0);
        step(); step();
        idle(0);
        rst = 1'b0;
        step();

        // Write then read, Latency 2
        drv(0, 1'b1, 1'b1, 4'hF, 32'h1008, 32'hDEAD_BEEF); step();
        drv(0, 1'b1, 1'b0, 4'hF, 32'h1008, 32'h0);          step();
        idle(0); at_neg();
        chk("wr_rvalid", {31'b0, rvalid[0]}, 32'h1);
        chk("wr_rdata", rdata[0], 32'h0);
        chk("wr_err", {31'b0, err[0]}, 32'h0);
        step(); at_neg();
        chk("rd_rvalid", {31'b0, rvalid[0]}, 32'h1);
        chk("rd_rdata", rdata[0], 32'hDEAD_BEEF);
        step();

        // Byte enables
        drv(0, 1'b1, 1'b1, 4'hF, 32'h1010, 32'h1122_3344);    step();
        drv(0, 1'b1, 1'b1, 4'b0101, 32'h1010, 32'hAABB_CCDD); step();
        drv(0, 1'b1, 1'b0, 4'h0, 32'h1010, 32'h0);            step();
        idle(0); step(); at_neg();
        chk("be_rdata", rdata[0], 32'h11BB_33DD);
        step();

        // Outstanding cap, Latency 3 / cap 2
        begin
            logic [5:0] pat;
            pat = 6'b011011;
            drv(1, 1'b1, 1'b1, 4'hF, 32'h1000, 32'h1); step();
            idle(1); repeat (4) step();
            drv(1, 1'b1, 1'b1, 4'hF, 32'h1004, 32'hCAFE_0000);
            for (int i = 0; i < 6; i++) begin
                at_neg();
                chk($sformatf("cap_gnt[%0d]", i), {31'b0, gnt[1]}, {31'b0, pat[i]});
                step();
            end
            idle(1); repeat (4) step();
        end

        // Error path: above and below the window, then read-back of word 0
        drv(0, 1'b1, 1'b1, 4'hF, 32'h1000, 32'h5A5A_A5A5); step();
        drv(0, 1'b1, 1'b0, 4'hF, 32'h1040, 32'h0);         step();
        drv(0, 1'b1, 1'b1, 4'hF, 32'h0FFC, 32'hFFFF_FFFF); at_neg();
        chk("err_wr0_err", {31'b0, err[0]}, 32'h0);
        step();
        drv(0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0); at_neg();
        chk("oob_rd_err", {31'b0, err[0]}, 32'h1);
        chk("oob_rd_rdata", rdata[0], 32'h0);
        step();
        idle(0); at_neg();
        chk("oob_wr_err", {31'b0, err[0]}, 32'h1);
        chk("oob_wr_rdata", rdata[0], 32'h0);
        step(); at_neg();
        chk("word0_readback", rdata[0], 32'h5A5A_A5A5);
        chk("word0_err", {31'b0, err[0]}, 32'h0);
        step();

        // Stall toggling then a continuous stream, Latency 1 / cap 1
        for (int i = 0; i < 8; i++) begin
            drv(2, 1'b1, 1'b1, 4'hF, 32'h1020, i);
            stall[2] = (i % 2 == 0);
            at_neg();
            chk($sformatf("stall_gnt[%0d]", i), {31'b0, gnt[2]}, {31'b0, ~stall[2]});
            step();
        end
        stall[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drv(2, 1'b1, 1'b1, 4'hF, 32'h1024, 32'h100 + i);
            at_neg();
            chk($sformatf("stream_gnt[%0d]", i), {31'b0, gnt[2]}, 32'h1);
            chk($sformatf("stream_rvalid[%0d]", i), {31'b0, rvalid[2]}, 32'h1);
            step();
        end
        idle(2); step(); step();

        // Reset in the middle of traffic
        drv(0, 1'b1, 1'b1, 4'hF, 32'h1018, 32'h0BAD_F00D); step();
        drv(0, 1'b1, 1'b0, 4'hF, 32'h1008, 32'h0);         step();
        rst = 1'b1; at_neg();
        chk("midrst_gnt", {31'b0, gnt[0]}, 32'h0);
        chk("midrst_rvalid", {31'b0, rvalid[0]}, 32'h0);
        chk("midrst_rdata", rdata[0], 32'h0);
        chk("midrst_err", {31'b0, err[0]}, 32'h0);
        step();
        rst = 1'b0; idle(0); at_neg();
        chk("postrst_rvalid_a", {31'b0, rvalid[0]}, 32'h0);
        step(); at_neg();
        chk("postrst_rvalid_b", {31'b0, rvalid[0]}, 32'h0);
        step();
        drv(0, 1'b1, 1'b0, 4'hF, 32'h1018, 32'h0); step();
        idle(0); step(); at_neg();
        chk("postrst_readback", rdata[0], 32'h0BAD_F00D);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
